shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, is the word length serialised per transfer and the depth of the downstream shift register; legal values are 2..16.
REQ-002 Parameter: CNT_W, default 4, is the bit-counter width; it SHALL satisfy 2**CNT_W >= WIDTH.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req0_valid  input  1  requester 0 offers a word.
REQ-006 Port: req0_data  input  WIDTH  requester 0 word; held stable while req0_valid=1 and req0_ready=0.
REQ-007 Port: req0_ready  output  1  requester 0 word is accepted this cycle.
REQ-008 Port: req1_valid / req1_data / req1_ready  same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-009 Port: D0  output  1  serial data into the shift register.
REQ-010 Port: shift  output  1  shift enable to the shift register.
REQ-011 Port: busy  output  1  high in the SHIFT and HOLD states.
REQ-012 Port: done  output  1  one-cycle pulse when a word is fully shifted.
REQ-013 Port: done_id  output  1  owner of the completed word; valid only while done=1.

Function
REQ-014 The block SHALL have three states: IDLE, SHIFT and HOLD; every output SHALL be decoded from registered state (Moore).
REQ-015 A transfer is accepted on a rising edge where reqN_valid=1 and reqN_ready=1.
REQ-016 In IDLE, if any valid is high, exactly one ready SHALL be asserted, chosen round-robin: the requester not served last wins when both are valid, and requester 0 wins after reset.
REQ-017 In SHIFT or HOLD, both ready outputs SHALL be 0.
REQ-018 At acceptance, the block SHALL capture the granted data into a WIDTH-bit buffer and the owner id, clear the counter and move to SHIFT.
REQ-019 In SHIFT, shift=1 and D0=buf[WIDTH-1-cnt], so the word is sent MSB first; cnt increments by 1 every cycle.
REQ-020 The last SHIFT cycle is cnt=WIDTH-1, after which the block moves to HOLD; there SHALL be exactly WIDTH shift cycles per word.
REQ-021 In HOLD, shift=0, D0=0, done=1 and done_id=owner; the round-robin pointer updates to the owner, and the next state is IDLE.
REQ-022 In IDLE, shift=0, D0=0 and done=0.
REQ-023 Latency: acceptance at edge T gives shift=1 during cycles T+1..T+WIDTH and done=1 during cycle T+WIDTH+1.
REQ-024 Throughput: at most one word per WIDTH+2 cycles, because the IDLE cycle is mandatory between words.
REQ-025 A valid that drops before acceptance SHALL leave no trace; there is no queuing beyond the one active word.
REQ-026 If a requester's valid is held through another requester's transfer, it SHALL be served next (no starvation).

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, cnt=0, buffer=0, the round-robin pointer to favour requester 0, and D0=0, shift=0, busy=0, done=0, done_id=0, req0_ready=0, req1_ready=0.
REQ-028 Reset during SHIFT or HOLD SHALL abort the word with no done pulse; the partially shifted data is not recovered.
REQ-029 After reset deasserts, the first edge with a valid high SHALL be able to accept a word.

Verification (WIDTH=4)
REQ-030 Single word: req0 sends 4'b1010 -> four shift=1 cycles with D0=1,0,1,0, then done=1 with done_id=0, then IDLE.
REQ-031 Simultaneous requests after reset: req0=4'b1100 and req1=4'b0011 both valid -> req0 is served first (D0=1,1,0,0, done_id=0), then req1 (D0=0,0,1,1, done_id=1).
REQ-032 Fairness: both valids held high for 4 words -> done_id sequence 0,1,0,1, with exactly 6 cycles between done pulses.
REQ-033 Reset mid-word: reset asserted after the 2nd shift cycle -> shift=0 and busy=0 immediately, no done; a fresh req1 word then completes normally.
REQ-034 All-zero word: req1 sends 4'b0000 -> four shift=1 cycles with D0=0, then done=1 with done_id=1.
REQ-035 Ready gating: req1_valid raised during req0's SHIFT -> req1_ready stays 0 until the IDLE cycle after HOLD, and req1's word is accepted there.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Handshake and serial-output bundle for shift_sequencer.
// Two requesters share one serialiser; the master side is the requester pair.
interface shift_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             D0;
  logic             shift;
  logic             busy;
  logic             done;
  logic             done_id;

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  D0, shift, busy, done, done_id
  );

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    output req0_ready, req1_ready,
    output D0, shift, busy, done, done_id
  );
endinterface

// File: rtl/shift_sequencer.sv
// Two-requester round-robin serialiser driving a shift register MSB first.
// One word in flight; a mandatory IDLE cycle separates consecutive words.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input logic          clk,
  input logic          reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               owner_q, owner_d;
  // last_q holds the requester served most recently; 1 favours requester 0
  logic               last_q, last_d;

  logic               gnt0, gnt1;
  logic [CNT_W-1:0]   bit_idx;
  logic               d0_bit;

  // round-robin grant among valid requesters, only offered in IDLE
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      gnt0 = bus.req0_valid &
             (!bus.req1_valid | last_q);
      gnt1 = bus.req1_valid &
             (!bus.req0_valid | !last_q);
    end
  end

  // next-state logic for the IDLE/SHIFT/HOLD sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          buf_d   = gnt1 ? bus.req1_data
                         : bus.req0_data;
          owner_d = gnt1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1))
          state_d = HOLD;
      end
      HOLD: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state registers; reset aborts any word in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign bit_idx = CNT_W'(WIDTH - 1) - cnt_q;

  // select the buffer bit for the current count, MSB first
  always_comb begin
    d0_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_idx == CNT_W'(i))
        d0_bit = buf_q[i];
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.shift      = (state_q == SHIFT);
  assign bus.D0         = (state_q == SHIFT) & d0_bit;
  assign bus.busy       = (state_q == SHIFT) |
                          (state_q == HOLD);
  assign bus.done       = (state_q == HOLD);
  assign bus.done_id    = (state_q == HOLD) & owner_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer at WIDTH=4.
// Expected bit streams and grant order are written out by hand.
module tb_shift_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   last_done;
  logic gap_on;

  shift_sequencer_if #(.WIDTH(4)) bus ();

  shift_sequencer #(
    .WIDTH(4),
    .CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // next edge accepts; then checks four shift cycles, HOLD and IDLE
  task automatic word(
    input logic [3:0] bits,
    input logic       id,
    input logic [1:0] clr,
    input logic       raise1
  );
    tick();
    if (clr[0]) bus.req0_valid = 1'b0;
    if (clr[1]) bus.req1_valid = 1'b0;
    if (raise1) bus.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("shift", bus.shift, 1'b1);
      chk("d0", bus.D0, bits[3-i]);
      chk("busy_s", bus.busy, 1'b1);
      chk("done_s", bus.done, 1'b0);
      chk("rdy0_s", bus.req0_ready, 1'b0);
      chk("rdy1_s", bus.req1_ready, 1'b0);
    end
    tick();
    chk("done", bus.done, 1'b1);
    chk("done_id", bus.done_id, id);
    chk("shift_h", bus.shift, 1'b0);
    chk("d0_h", bus.D0, 1'b0);
    chk("busy_h", bus.busy, 1'b1);
    chk("rdy1_h", bus.req1_ready, 1'b0);
    if (gap_on) chk("gap", cyc - last_done, 6);
    last_done = cyc;
    tick();
    chk("done_i", bus.done, 1'b0);
    chk("busy_i", bus.busy, 1'b0);
    chk("shift_i", bus.shift, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_shift", bus.shift, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_d0", bus.D0, 1'b0);
    chk("rst_id", bus.done_id, 1'b0);
    chk("rst_rdy0", bus.req0_ready, 1'b0);
    chk("rst_rdy1", bus.req1_ready, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    last_done = 0;
    gap_on = 1'b0;
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    #2;

    // single word from req0, valid already high during reset
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b1010;
    do_reset();
    chk("w1_rdy0", bus.req0_ready, 1'b1);
    chk("w1_rdy1", bus.req1_ready, 1'b0);
    word(4'b1010, 1'b0, 2'b01, 1'b0);

    // simultaneous requests after reset, then fairness run
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b1100;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'b0011;
    #1;
    chk("sim_rdy0", bus.req0_ready, 1'b1);
    chk("sim_rdy1", bus.req1_ready, 1'b0);
    word(4'b1100, 1'b0, 2'b00, 1'b0);
    chk("sim2_rdy0", bus.req0_ready, 1'b0);
    chk("sim2_rdy1", bus.req1_ready, 1'b1);
    gap_on = 1'b1;
    word(4'b0011, 1'b1, 2'b00, 1'b0);
    word(4'b1100, 1'b0, 2'b00, 1'b0);
    word(4'b0011, 1'b1, 2'b00, 1'b0);
    word(4'b1100, 1'b0, 2'b00, 1'b0);
    word(4'b0011, 1'b1, 2'b11, 1'b0);
    gap_on = 1'b0;

    // reset after the second shift cycle aborts the word
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b1001;
    #1;
    chk("ab_rdy0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    chk("ab_s1", bus.D0, 1'b1);
    tick();
    chk("ab_s2", bus.shift, 1'b1);
    reset = 1'b1;
    #1;
    chk("ab_shift", bus.shift, 1'b0);
    chk("ab_busy", bus.busy, 1'b0);
    chk("ab_done", bus.done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ab_nodone", bus.done, 1'b0);
      if (i == 1) reset = 1'b0;
    end
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'b0110;
    #1;
    chk("ab_rdy1", bus.req1_ready, 1'b1);
    word(4'b0110, 1'b1, 2'b10, 1'b0);

    // all-zero word from req1
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'b0000;
    #1;
    chk("z_rdy1", bus.req1_ready, 1'b1);
    word(4'b0000, 1'b1, 2'b10, 1'b0);

    // req1 raised during req0's word waits for IDLE
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b0111;
    bus.req1_data  = 4'b1011;
    #1;
    chk("g_rdy0", bus.req0_ready, 1'b1);
    chk("g_rdy1", bus.req1_ready, 1'b0);
    word(4'b0111, 1'b0, 2'b01, 1'b1);
    chk("g2_rdy1", bus.req1_ready, 1'b1);
    chk("g2_rdy0", bus.req0_ready, 1'b0);
    word(4'b1011, 1'b1, 2'b10, 1'b0);

    // dropped valid leaves no trace
    bus.req0_valid = 1'b1;
    #1;
    bus.req0_valid = 1'b0;
    tick();
    chk("drop_busy", bus.busy, 1'b0);
    chk("drop_shift", bus.shift, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
